// File: rtl/debounce_pkg.sv
// Shared constants, per-channel output bundle and width helper for the button conditioner.
package debounce_pkg;
  localparam int DEBOUNCE_DIV_DEFAULT    = 500_000;
  localparam int DEBOUNCE_STABLE_DEFAULT = 3;
  localparam int DEBOUNCE_LONG_DEFAULT   = 2000;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_press;
  } chan_out_t;

  // ceil(log2(n)), never less than 1 bit
  function automatic int clog2w(input int n);
    int v;
    int w;
    v = n - 1;
    w = 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/clock_enable.sv
// Free-running divider: one-clk tick every DIV clk cycles, shared by all channels.
module clock_enable
  import debounce_pkg::*;
#(
  parameter int DIV = DEBOUNCE_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = clog2w(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CNT_LAST);
endmodule

// File: rtl/debounce_channel.sv
// One button lane: 2-flop synchroniser, tick-qualified stability filter, level/edge pulses.
// Optional hold counter for long_press under DEBOUNCE_LONG_PRESS_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE = DEBOUNCE_STABLE_DEFAULT
`ifdef DEBOUNCE_LONG_PRESS_EN
  , parameter int LONG_TICKS = DEBOUNCE_LONG_DEFAULT
`endif
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      tick,
  input  logic      btn,
  output chan_out_t q
);
  localparam int CW = clog2w(STABLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level, press, rel, lp;
  logic          s, flip;

  always_comb begin
    s    = sync[1];
    flip = tick && (s != level) && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else sync <= {sync[0], btn};
  end

  // any agreeing sample restarts the run of disagreeing ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        if (s == level) cnt <= '0;
        else if (flip) begin
          cnt   <= '0;
          level <= ~level;
          press <= ~level;
          rel   <= level;
        end else cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = clog2w(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [HW-1:0] hold;

  // counts ticks spent high; a releasing tick clears instead of counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
      lp   <= 1'b0;
    end else begin
      lp <= 1'b0;
      if (!level || flip) hold <= '0;
      else if (tick && hold != HOLD_MAX) begin
        hold <= hold + HW'(1);
        lp   <= (hold == HOLD_MAX - HW'(1));
      end
    end
  end
`else
  assign lp = 1'b0;
`endif

  assign q = '{level: level, press: press, rel: rel, long_press: lp};
endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: shared sample tick, CHANNELS independent lanes.
// Optional long-press detection: define DEBOUNCE_LONG_PRESS_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DIV        = DEBOUNCE_DIV_DEFAULT,
  parameter int STABLE     = DEBOUNCE_STABLE_DEFAULT,
  parameter int LONG_TICKS = DEBOUNCE_LONG_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] buttons,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_p,  // 'release' is a reserved word
  output logic [CHANNELS-1:0] long_press
);
  if (CHANNELS < 1 || DIV < 1 || STABLE < 1 || LONG_TICKS < 1) begin : g_bad_cfg
    $error("debounce_multi: all parameters must be >= 1");
  end

  logic      tick;
  chan_out_t co [CHANNELS];

  clock_enable #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (~reset_n),
    .tick (tick)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE     (STABLE)
`ifdef DEBOUNCE_LONG_PRESS_EN
      , .LONG_TICKS (LONG_TICKS)
`endif
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .btn     (buttons[g]),
      .q       (co[g])
    );
    assign level[g]      = co[g].level;
    assign press[g]      = co[g].press;
    assign release_p[g]  = co[g].rel;
    assign long_press[g] = co[g].long_press;
  end
endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: two configurations (DIV=4/STABLE=3 and DIV=1/STABLE=1)
// checked cycle by cycle against a sample-counting reference model.
module tb_debounce_multi;
  localparam int CH = 4;
  localparam int LT = 5;
  int divs [2] = '{4, 1};
  int sts  [2] = '{3, 1};

  logic clk = 0;
  logic reset_n = 0;
  logic [CH-1:0] buttons = '0;
  logic [CH-1:0] lv_a, pr_a, rl_a, lp_a, lv_b, pr_b, rl_b, lp_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  debounce_multi #(.CHANNELS(CH), .DIV(4), .STABLE(3), .LONG_TICKS(LT)) dut_a (
    .clk(clk), .reset_n(reset_n), .buttons(buttons),
    .level(lv_a), .press(pr_a), .release_p(rl_a), .long_press(lp_a));

  debounce_multi #(.CHANNELS(CH), .DIV(1), .STABLE(1), .LONG_TICKS(LT)) dut_b (
    .clk(clk), .reset_n(reset_n), .buttons(buttons),
    .level(lv_b), .press(pr_b), .release_p(rl_b), .long_press(lp_b));

  typedef struct packed {
    logic [CH-1:0] lv, pr, rl, lp;
  } exp_t;

  exp_t q_a[$], q_b[$];

  // reference model: button history, run length of disagreeing samples, hold tick count
  int            divc [2];
  logic [CH-1:0] h1 [2], h2 [2], lvl [2];
  int            run  [2][CH];
  int            held [2][CH];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      divc[d] = 0; h1[d] = '0; h2[d] = '0; lvl[d] = '0;
      for (int c = 0; c < CH; c++) begin run[d][c] = 0; held[d][c] = 0; end
    end
  endtask

  task automatic model_step(input int d, input logic [CH-1:0] b, output exp_t e);
    bit tk;
    logic was;
    e  = '0;
    tk = (divc[d] == divs[d] - 1);
    divc[d] = (divc[d] + 1) % divs[d];
    for (int c = 0; c < CH; c++) begin
      was = lvl[d][c];
      if (tk) begin
        if (h2[d][c] == lvl[d][c]) run[d][c] = 0;
        else begin
          run[d][c]++;
          if (run[d][c] == sts[d]) begin
            lvl[d][c] = ~lvl[d][c];
            run[d][c] = 0;
            if (lvl[d][c]) e.pr[c] = 1'b1;
            else e.rl[c] = 1'b1;
          end
        end
      end
`ifdef DEBOUNCE_LONG_PRESS_EN
      if (!(was && lvl[d][c])) held[d][c] = 0;
      else if (tk && held[d][c] < LT) begin
        held[d][c]++;
        if (held[d][c] == LT) e.lp[c] = 1'b1;
      end
`else
      held[d][c] = was ? 1 : 0;
`endif
    end
    h2[d] = h1[d];
    h1[d] = b;
    e.lv  = lvl[d];
  endtask

  always @(posedge clk) begin
    exp_t ea, eb;
    if (!reset_n) begin
      model_reset();
      q_a.push_back('0);
      q_b.push_back('0);
    end else begin
      model_step(0, buttons, ea);
      model_step(1, buttons, eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
  end

  int cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      total++;
      if ({lv_a, pr_a, rl_a, lp_a} !== e) begin
        bad++;
        if (bad < 30)
          $display("FAIL cfgA cyc=%0d got lv=%h pr=%h rl=%h lp=%h want lv=%h pr=%h rl=%h lp=%h",
                   cyc, lv_a, pr_a, rl_a, lp_a, e.lv, e.pr, e.rl, e.lp);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      total++;
      if ({lv_b, pr_b, rl_b, lp_b} !== e) begin
        bad++;
        if (bad < 30)
          $display("FAIL cfgB cyc=%0d got lv=%h pr=%h rl=%h lp=%h want lv=%h pr=%h rl=%h lp=%h",
                   cyc, lv_b, pr_b, rl_b, lp_b, e.lv, e.pr, e.rl, e.lp);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CH-1:0] b, input int n);
    buttons = b;
    wait_cyc(n);
  endtask

  // reset asserted between edges; outputs must clear without waiting for a clock
  task automatic async_reset(input int hold_cycles);
    @(negedge clk);
    #1;
    reset_n = 0;
    #1;
    total++;
    if ({lv_a, pr_a, rl_a, lp_a, lv_b, pr_b, rl_b, lp_b} !== '0) begin
      bad++;
      $display("FAIL async_reset got a=%h b=%h want 0",
               {lv_a, pr_a, rl_a, lp_a}, {lv_b, pr_b, rl_b, lp_b});
    end
    wait_cyc(hold_cycles);
    reset_n = 1;
  endtask

  initial begin
    logic [CH-1:0] r;
    wait_cyc(3);
    reset_n = 1;
    drive(4'h0, 20);
    // reset in the middle of a count, then re-accept from scratch
    drive(4'hF, 9);
    async_reset(3);
    drive(4'hF, 30);
    drive(4'h0, 30);
    // clean press on channel 0
    drive(4'h1, 40);
    drive(4'h0, 30);
    // bounce on channel 1 across ticks, then steady
    drive(4'h2, 4); drive(4'h0, 4); drive(4'h2, 4); drive(4'h0, 4);
    drive(4'h2, 30);
    drive(4'h0, 30);
    // simultaneous events
    drive(4'b1010, 30);
    drive(4'b0101, 30);
    drive(4'h0, 30);
    // long hold on channel 2, release, re-press
    drive(4'h4, 60);
    drive(4'h0, 20);
    drive(4'h4, 60);
    drive(4'h0, 30);
    // randomized phases, mixing steady holds with short glitches
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) r = buttons ^ (4'(1) << $urandom_range(0, CH - 1));
      else r = 4'($urandom);
      drive(r, $urandom_range(1, (i % 5 == 0) ? 60 : 20));
      if ($urandom_range(0, 40) == 0) async_reset($urandom_range(1, 4));
    end
    drive(4'h0, 40);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
